// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : IF stage - owns the PC, drives instruction memory, fills IF/ID.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] NOP_WORD = 16'h0000,
    parameter logic [4:0]  HALT_OP  = 5'b00001,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        stall,
    input  logic        redirect,
    input  logic [7:0]  redirect_addr,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [15:0] id_instr,
    output logic [7:0]  id_pc,
    output logic [7:0]  id_npc,
    output logic        id_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_pc;
    logic [7:0]  w_pc_nxt;
    logic [7:0]  w_pc_inc;
    logic [15:0] r_id_instr;
    logic [15:0] w_id_instr_nxt;
    logic [7:0]  r_id_pc;
    logic [7:0]  w_id_pc_nxt;
    logic [7:0]  r_id_npc;
    logic [7:0]  w_id_npc_nxt;
    logic        r_id_valid;
    logic        w_id_valid_nxt;
    logic        r_halted;
    logic        w_is_halt;

    assign w_pc_inc  = r_pc + 8'd1;
    assign w_is_halt = (imem_rdata[15:11] == HALT_OP);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_id_instr_nxt = r_id_instr;
        w_id_pc_nxt    = r_id_pc;
        w_id_npc_nxt   = r_id_npc;
        w_id_valid_nxt = r_id_valid;
        if (enable) begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt    = S_RUN;
                    w_id_instr_nxt = NOP_WORD;
                    w_id_valid_nxt = 1'b0;
                end
                S_RUN: begin
                    // A redirect wins over stall/HALT: the fetched word is wrong-path.
                    if (redirect) begin
                        w_pc_nxt       = redirect_addr;
                        w_id_instr_nxt = NOP_WORD;
                        w_id_valid_nxt = 1'b0;
                    end else if (!stall) begin
                        w_id_instr_nxt = imem_rdata;
                        w_id_pc_nxt    = r_pc;
                        w_id_npc_nxt   = w_pc_inc;
                        w_id_valid_nxt = 1'b1;
                        if (w_is_halt) begin
                            w_state_nxt = S_HALTED;
                        end else begin
                            w_pc_nxt = w_pc_inc;
                        end
                    end
                end
                S_HALTED: begin
                    w_id_instr_nxt = NOP_WORD;
                    w_id_valid_nxt = 1'b0;
                    if (redirect) begin
                        w_pc_nxt    = redirect_addr;
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt    = S_IDLE;
                    w_id_instr_nxt = NOP_WORD;
                    w_id_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_id_instr <= NOP_WORD;
            r_id_pc    <= 8'h00;
            r_id_npc   <= 8'h00;
            r_id_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_id_instr <= w_id_instr_nxt;
            r_id_pc    <= w_id_pc_nxt;
            r_id_npc   <= w_id_npc_nxt;
            r_id_valid <= w_id_valid_nxt;
            r_halted   <= (w_state_nxt == S_HALTED);
        end
    end

    assign imem_addr = r_pc;
    assign id_instr  = r_id_instr;
    assign id_pc     = r_id_pc;
    assign id_npc    = r_id_npc;
    assign id_valid  = r_id_valid;
    assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed + randomized checks of fetch_stage against a rule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] id_instr;
    logic [7:0]  id_pc;
    logic [7:0]  id_npc;
    logic        id_valid;
    logic        halted;

    logic [15:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the stage: mode 0=waiting for start bubble, 1=fetching, 2=halted
    int          m_pc;
    int          m_mode;
    logic [15:0] m_instr;
    int          m_ipc;
    int          m_inpc;
    logic        m_valid;

    fetch_stage dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_npc        (id_npc),
        .id_valid      (id_valid),
        .halted        (halted)
    );

    assign imem_rdata = mem[imem_addr];

    always #5 clock = ~clock;

    function automatic logic [15:0] rand_word(input bit allow_halt);
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:11] == 5'b00001) w[15:11] = 5'b00010;
        if (allow_halt && ($urandom_range(0, 9) == 0)) w[15:11] = 5'b00001;
        return w;
    endfunction

    function automatic logic [41:0] exp_vec();
        return {8'(m_pc), m_instr, 8'(m_ipc), 8'(m_inpc), m_valid, (m_mode == 2)};
    endfunction

    function automatic logic [41:0] dut_vec();
        return {imem_addr, id_instr, id_pc, id_npc, id_valid, halted};
    endfunction

    task automatic model_reset();
        m_pc = 0; m_mode = 0; m_instr = 16'h0000; m_ipc = 0; m_inpc = 0; m_valid = 1'b0;
    endtask

    // Drive inputs, advance the model by one cycle, then wait past the edge.
    task automatic step(input logic en, input logic st, input logic rd, input logic [7:0] ra);
        logic [15:0] w;
        enable = en; stall = st; redirect = rd; redirect_addr = ra;
        if (en) begin
            if (m_mode == 0) begin
                m_mode = 1; m_instr = 16'h0000; m_valid = 1'b0;
            end else if (rd) begin
                m_pc = ra; m_mode = 1; m_instr = 16'h0000; m_valid = 1'b0;
            end else if (m_mode == 2) begin
                m_instr = 16'h0000; m_valid = 1'b0;
            end else if (!st) begin
                w = mem[m_pc];
                m_instr = w; m_ipc = m_pc; m_inpc = (m_pc + 1) % 256; m_valid = 1'b1;
                if (w[15:11] == 5'b00001) m_mode = 2;
                else m_pc = (m_pc + 1) % 256;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (dut_vec() !== 42'h0) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", dut_vec(), 42'h0);
        end
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic test_fetch_seq();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({id_valid, id_instr, imem_addr} !== {1'b0, 16'h0000, 8'h00}) begin
            n_fail++; $display("FAIL start_bubble: got v=%b i=%h a=%h want v=0 i=0000 a=00", id_valid, id_instr, imem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            n_checks++;
            if ({id_instr, id_pc, id_npc, id_valid} !== {mem[i], 8'(i), 8'(i + 1), 1'b1}) begin
                n_fail++; $display("FAIL fetch_word%0d: got i=%h pc=%h npc=%h v=%b want i=%h pc=%h npc=%h v=1",
                                   i, id_instr, id_pc, id_npc, id_valid, mem[i], 8'(i), 8'(i + 1));
            end
        end
    endtask

    task automatic test_stall();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'h00);
            n_checks++;
            if ({id_instr, id_pc, imem_addr} !== {mem[4], 8'h04, 8'h05}) begin
                n_fail++; $display("FAIL stall_hold%0d: got i=%h pc=%h a=%h want i=%h pc=04 a=05", i, id_instr, id_pc, imem_addr, mem[4]);
            end
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({id_instr, id_pc, id_valid} !== {mem[5], 8'h05, 1'b1}) begin
            n_fail++; $display("FAIL stall_resume: got i=%h pc=%h v=%b want i=%h pc=05 v=1", id_instr, id_pc, id_valid, mem[5]);
        end
    endtask

    task automatic test_redirect();
        int guard = 0;
        while (imem_addr !== 8'd25 && guard < 40) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            guard++;
        end
        n_checks++;
        if (imem_addr !== 8'd25) begin
            n_fail++; $display("FAIL reach_pc25: got a=%h want 19", imem_addr);
        end
        step(1'b1, 1'b1, 1'b1, 8'h06);
        n_checks++;
        if ({id_valid, id_instr, imem_addr} !== {1'b0, 16'h0000, 8'h06}) begin
            n_fail++; $display("FAIL redirect_bubble: got v=%b i=%h a=%h want v=0 i=0000 a=06", id_valid, id_instr, imem_addr);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({id_instr, id_pc, id_valid} !== {mem[6], 8'h06, 1'b1}) begin
            n_fail++; $display("FAIL redirect_target: got i=%h pc=%h v=%b want i=%h pc=06 v=1", id_instr, id_pc, id_valid, mem[6]);
        end
    endtask

    task automatic test_halt();
        int guard = 0;
        while (imem_addr !== 8'd28 && guard < 40) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            guard++;
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({id_instr, id_pc, id_valid, halted, imem_addr} !== {16'h0ABC, 8'd28, 1'b1, 1'b1, 8'd28}) begin
            n_fail++; $display("FAIL halt_enter: got i=%h pc=%h v=%b h=%b a=%h want i=0abc pc=1c v=1 h=1 a=1c",
                               id_instr, id_pc, id_valid, halted, imem_addr);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            n_checks++;
            if ({id_instr, id_valid, halted, imem_addr, id_pc} !== {16'h0000, 1'b0, 1'b1, 8'd28, 8'd28}) begin
                n_fail++; $display("FAIL halt_bubble%0d: got i=%h v=%b h=%b a=%h pc=%h want i=0000 v=0 h=1 a=1c pc=1c",
                                   i, id_instr, id_valid, halted, imem_addr, id_pc);
            end
        end
        // Leave HALTED back onto the HALT word, so the next exit happens with it in IF/ID.
        step(1'b1, 1'b0, 1'b1, 8'd28);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({id_instr, halted} !== {16'h0ABC, 1'b1}) begin
            n_fail++; $display("FAIL halt_reenter: got i=%h h=%b want i=0abc h=1", id_instr, halted);
        end
        step(1'b1, 1'b0, 1'b1, 8'h10);
        n_checks++;
        if ({halted, id_valid, imem_addr} !== {1'b0, 1'b0, 8'h10}) begin
            n_fail++; $display("FAIL halt_exit: got h=%b v=%b a=%h want h=0 v=0 a=10", halted, id_valid, imem_addr);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({id_instr, id_pc, id_valid} !== {mem[16], 8'h10, 1'b1}) begin
            n_fail++; $display("FAIL halt_resume: got i=%h pc=%h v=%b want i=%h pc=10 v=1", id_instr, id_pc, id_valid, mem[16]);
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b0, 1'b1, 8'hFE);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({id_instr, id_pc, id_npc, imem_addr} !== {mem[255], 8'hFF, 8'h00, 8'h00}) begin
            n_fail++; $display("FAIL pc_wrap: got i=%h pc=%h npc=%h a=%h want i=%h pc=ff npc=00 a=00",
                               id_instr, id_pc, id_npc, imem_addr, mem[255]);
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 8'h40);
            n_checks++;
            if ({imem_addr, id_pc, id_instr} !== {8'h00, 8'hFF, mem[255]} || dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL enable_freeze%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++;
        if ({id_instr, id_pc, imem_addr} !== {mem[0], 8'h00, 8'h01}) begin
            n_fail++; $display("FAIL enable_resume: got i=%h pc=%h a=%h want i=%h pc=00 a=01", id_instr, id_pc, imem_addr, mem[0]);
        end
    endtask

    task automatic test_async_reset();
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (dut_vec() !== 42'h0) begin
            n_fail++; $display("FAIL async_reset: got %h want %h", dut_vec(), 42'h0);
        end
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic test_random();
        for (int a = 0; a < 256; a++) mem[a] = rand_word(1'b1);
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 9) == 0), 8'($urandom));
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        clock = 1'b0; reset = 1'b0; enable = 1'b0; stall = 1'b0;
        redirect = 1'b0; redirect_addr = 8'h00;
        for (int a = 0; a < 256; a++) mem[a] = rand_word(1'b0);
        mem[0] = 16'h4A05; mem[1] = 16'h5B12; mem[2] = 16'h0000; mem[3] = 16'h6001;
        mem[28] = 16'h0ABC;
        model_reset();
        #2;
        test_reset();
        test_fetch_seq();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_enable();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
